// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: splits 32-bit MEM-stage accesses into two timed 16-bit SRAM transfers, stalling via ready.
// Optional one-entry read buffer enabled by MEM_READ_BUF_EN.
module mem_stage_sram_ctrl #(
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_we_n,
  output logic              sram_oe_n
);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD = CW'(WAIT_CYCLES - 2);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic              wr_q;
  logic [ADDR_W-2:0] idx_q;
  logic [15:0]       whi_q;
  logic              req;
  logic              last;
  logic [ADDR_W-2:0] idx;
  assign req   = rd_en | wr_en;
  assign last  = cnt == LAST;
  assign idx   = (ADDR_W-1)'((address - 32'(BASE_ADDR)) >> 2);
  assign ready = (state == IDLE && !req) || state == DONE;
`ifdef MEM_READ_BUF_EN
  logic              buf_v;
  logic [ADDR_W-2:0] buf_tag;
  logic [31:0]       buf_d;
  logic              hit;
  assign hit = buf_v && buf_tag == idx && rd_en && !wr_en;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      whi_q       <= '0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
`ifdef MEM_READ_BUF_EN
      buf_v       <= 1'b0;
      buf_tag     <= '0;
      buf_d       <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req) begin
          wr_q  <= wr_en;
          idx_q <= idx;
          whi_q <= wdata[31:16];
          cnt   <= '0;
`ifdef MEM_READ_BUF_EN
          if (wr_en && buf_tag == idx) buf_d <= wdata;
          if (hit) begin
            rdata <= buf_d;
            state <= DONE;
          end else
`endif
          begin
            state     <= LO;
            sram_addr <= {idx, 1'b0};
            if (wr_en) sram_dq_out <= wdata[15:0];
            sram_we_n <= !wr_en;
            sram_oe_n <= wr_en;
          end
        end
        LO, HI: if (!last) begin
          cnt <= cnt + 1'b1;
          // release the write strobe one cycle early so address/data are held past we_n rising
          if (cnt == HOLD) sram_we_n <= 1'b1;
        end else if (state == LO) begin
          cnt       <= '0;
          state     <= HI;
          sram_addr <= {idx_q, 1'b1};
          if (wr_q) sram_dq_out <= whi_q;
          else rdata[15:0] <= sram_dq_in;
          sram_we_n <= !wr_q;
        end else begin
          cnt       <= '0;
          state     <= DONE;
          sram_we_n <= 1'b1;
          sram_oe_n <= 1'b1;
          if (!wr_q) rdata[31:16] <= sram_dq_in;
`ifdef MEM_READ_BUF_EN
          if (!wr_q) begin
            buf_v   <= 1'b1;
            buf_tag <= idx_q;
            buf_d   <= {sram_dq_in, rdata[15:0]};
          end
`endif
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: directed bench with an SRAM model and a transaction-level reference checked every cycle.
module tb_mem_stage_sram_ctrl;
  localparam int W = 5;
  localparam int DN = 2 * W + 1;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_we_n, sram_oe_n;
  int checks = 0;
  int errs = 0;

  mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(1024), .ADDR_W(18)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:63];
  bit inited = 0;
  assign sram_dq_in = sram_oe_n ? 16'h0 : mem[sram_addr[5:0]];
  always @(negedge clk) begin
    if (!inited) begin
      for (int i = 0; i < 64; i++) mem[i] = 16'hA5A5;
      inited = 1;
    end else if (!sram_we_n) mem[sram_addr[5:0]] = sram_dq_out;
  end

  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction

  // reference: p = cycles since the request cycle (-1 when idle), words keyed by word index
  int          p;
  logic        m_wr, m_hit;
  logic [16:0] m_idx;
  logic [31:0] m_wd, m_rd;
  logic [31:0] refm [int];
  logic        bv;
  logic [16:0] btag;
  logic [31:0] bdata;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      p = -1; m_rd = 0; bv = 0;
    end else if (p < 0) begin
      if (rd_en | wr_en) begin
        m_wr  = wr_en;
        m_idx = 17'((address - 32'd1024) >> 2);
        m_wd  = wdata;
`ifdef MEM_READ_BUF_EN
        m_hit = bv && btag == m_idx && !wr_en;
`else
        m_hit = 0;
`endif
        if (m_hit) begin m_rd = bdata; p = DN; end
        else p = 1;
      end
    end else if (p == DN) begin
      if (m_wr) begin
        refm[int'(m_idx)] = m_wd;
        if (btag == m_idx) bdata = m_wd;
      end
      p = -1;
    end else begin
      p++;
      if (p == DN && !m_wr) begin
        m_rd = refm[int'(m_idx)];
        bv = 1; btag = m_idx; bdata = m_rd;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_we_n", {31'd0, sram_we_n}, 1);
      chk("rst_oe_n", {31'd0, sram_oe_n}, 1);
      chk("rst_rdata", rdata, 0);
    end else if (p < 0 || p == DN) begin
      chk("ready", {31'd0, ready}, (p == DN) ? 1 : {31'd0, !(rd_en | wr_en)});
      chk("idle_we_n", {31'd0, sram_we_n}, 1);
      chk("idle_oe_n", {31'd0, sram_oe_n}, 1);
      chk("rdata", rdata, m_rd);
    end else begin
      automatic int  j  = (p - 1) % W;
      automatic bit  hi = p > W;
      chk("busy_ready", {31'd0, ready}, 0);
      chk("sram_addr", {14'd0, sram_addr}, {14'd0, m_idx, hi});
      chk("oe_n", {31'd0, sram_oe_n}, {31'd0, m_wr});
      chk("we_n", {31'd0, sram_we_n}, {31'd0, !(m_wr && j < W - 1)});
      if (m_wr) begin
        chk("dq_out", {16'd0, sram_dq_out}, {16'd0, hi ? m_wd[31:16] : m_wd[15:0]});
        chk("wr_rdata_hold", rdata, m_rd);
      end
    end
  end

  task automatic acc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output int lo, output int oel, output int wel, output logic [31:0] rd);
    bit done = 0;
    rd_en = r; wr_en = w; address = a; wdata = d;
    lo = 0; oel = 0; wel = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!sram_oe_n) oel++;
      if (!sram_we_n) wel++;
      if (ready) done = 1;
      else lo++;
    end
    if (!done) chk("timeout", 1, 0);
    rd = rdata;
    @(posedge clk); #1;
    rd_en = 0; wr_en = 0;
  endtask

  int lo, oel, wel, rh;
  logic [31:0] rd;
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", {14'd0, sram_addr}, 0);
    chk("rst_dq", {16'd0, sram_dq_out}, 0);
    chk("rst_ready", {31'd0, ready}, 1);
    rst = 1;
    rh = 0;
    repeat (20) begin @(negedge clk); if (ready && sram_we_n && sram_oe_n) rh++; end
    chk("idle20", rh, 20);
    @(posedge clk); #1;
    acc(0, 1, 1028, 32'hDEADBEEF, lo, oel, wel, rd);
    chk("wr_lat", lo, 11); chk("wr_we_low", wel, 8); chk("wr_oe_low", oel, 0);
    chk("mem2", {16'd0, mem[2]}, 32'hBEEF); chk("mem3", {16'd0, mem[3]}, 32'hDEAD);
    acc(1, 0, 1028, 0, lo, oel, wel, rd);
    chk("rd_lat", lo, 11); chk("rd_oe_low", oel, 10); chk("rd_we_low", wel, 0);
    chk("rd_val", rd, 32'hDEADBEEF);
    acc(1, 1, 1032, 32'h12345678, lo, oel, wel, rd);
    chk("both_lat", lo, 11); chk("both_oe", oel, 0); chk("both_rdata", rd, 32'hDEADBEEF);
    chk("mem4", {16'd0, mem[4]}, 32'h5678); chk("mem5", {16'd0, mem[5]}, 32'h1234);
    acc(1, 0, 1028, 0, lo, oel, wel, rd);
    chk("rd2_val", rd, 32'hDEADBEEF);
`ifdef MEM_READ_BUF_EN
    chk("hit_lat", lo, 1); chk("hit_oe", oel, 0);
`else
    chk("rd2_lat", lo, 11); chk("rd2_oe", oel, 10);
`endif
    acc(0, 1, 1028, 32'h0, lo, oel, wel, rd);
    acc(1, 0, 1028, 0, lo, oel, wel, rd);
    chk("rd3_val", rd, 32'h0);
`ifdef MEM_READ_BUF_EN
    chk("hit2_lat", lo, 1);
`else
    chk("rd3_lat", lo, 11);
`endif
    acc(1, 0, 1032, 0, lo, oel, wel, rd);
    chk("b2b_val", rd, 32'h12345678);
    wr_en = 1; address = 1040; wdata = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    #1;
    chk("abort_we_n", {31'd0, sram_we_n}, 1);
    chk("abort_rdata", rdata, 0);
    wr_en = 0;
    @(posedge clk); #3 rst = 1;
    repeat (12) @(posedge clk);
    chk("abort_mem9", {16'd0, mem[9]}, 32'hA5A5);
    #1;
    acc(1, 0, 1028, 0, lo, oel, wel, rd);
    chk("post_rst_lat", lo, 11);
    chk("post_rst_val", rd, 32'h0);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
